// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_share_ctrl
//  Purpose  : Sequencing and sharing controller for the calculator's single
//             combinational N-bit unsigned multiplier. It arbitrates
//             round-robin between two operand requesters and latches the
//             winning operands. It drives the shared multiplier, registers
//             the product and returns it over a valid/ready response channel
//             tagged with the requester ID.
//  Ports    :
//             clk, rst_n          - clock, asynchronous active-low reset
//             reqX_valid/ready    - requester X operand handshake (X = 0,1)
//             reqX_a, reqX_b      - requester X operands (N bits)
//             mul_a, mul_b        - operands to the shared multiplier
//             mul_p               - product back from the multiplier (2N bits)
//             rsp_valid/ready     - response handshake
//             rsp_product, rsp_id - registered product and owning requester
//             busy                - controller is not idle
//             op_count            - completed responses, wraps mod 2^CNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module mult_share_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,

    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [2*N-1:0]   mul_p,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*N-1:0]   rsp_product,
    output logic             rsp_id,

    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [N-1:0]       r_op_a;
    logic [N-1:0]       r_op_b;
    logic               r_op_id;
    logic               r_ptr;          // requester that wins a tie
    logic [2*N-1:0]     r_rsp_product;
    logic               r_rsp_id;
    logic               r_rsp_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_idle;
    logic               w_grant0;
    logic               w_grant1;

    // ------------------------------------------------------------------------
    // Arbitration. A lone valid requester always wins; on a tie the pointer
    // decides. The two grants are mutually exclusive by construction, and
    // they are re-evaluated every cycle so a withdrawn request leaves no
    // trace.
    // ------------------------------------------------------------------------
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
    assign w_grant1 = req1_valid & (~req0_valid |  r_ptr);

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;

    // The multiplier sees the operand registers at all times, so its inputs
    // hold the last accepted operands while idle.
    assign mul_a       = r_op_a;
    assign mul_b       = r_op_b;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_rsp_product;
    assign rsp_id      = r_rsp_id;
    assign busy        = r_busy;
    assign op_count    = r_op_count;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_op_id       <= 1'b0;
            r_ptr         <= 1'b0;
            r_rsp_product <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0_ready) begin
                        r_op_a  <= req0_a;
                        r_op_b  <= req0_b;
                        r_op_id <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else if (req1_ready) begin
                        r_op_a  <= req1_a;
                        r_op_b  <= req1_b;
                        r_op_id <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end

                // The multiplier has had a full cycle to settle on the
                // operand registers; capture its result.
                S_CALC: begin
                    r_rsp_product <= mul_p;
                    r_rsp_id      <= r_op_id;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + c_cnt_one;
                        // Hand priority to the requester not just served.
                        r_ptr       <= ~r_rsp_id;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_share_ctrl
//  Purpose  : Self-checking bench for mult_share_ctrl. A transaction-level
//             reference (expected winner, tie pointer, completed-operation
//             count) predicts every observed output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [N-1:0]     req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [N-1:0]     req1_a, req1_b;
    logic [N-1:0]     mul_a, mul_b;
    logic [2*N-1:0]   mul_p;
    logic             rsp_valid, rsp_ready;
    logic [2*N-1:0]   rsp_product;
    logic             rsp_id;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state
    int m_ptr = 0;
    int m_cnt = 0;

    // The shared combinational multiplier lives in the environment.
    assign mul_p = mul_a * mul_b;

    mult_share_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation from the idle state. Valids stay asserted
    // through CALC and RESP so that ready suppression is exercised.
    task automatic do_op(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1,
                         input int stall);
        int win;
        int ea, eb;
        win = (v0 && v1) ? m_ptr : (v0 ? 0 : 1);
        ea  = (win == 1) ? a1 : a0;
        eb  = (win == 1) ? b1 : b0;

        req0_valid = v0; req0_a = a0[N-1:0]; req0_b = b0[N-1:0];
        req1_valid = v1; req1_a = a1[N-1:0]; req1_b = b1[N-1:0];
        rsp_ready  = 1'b0;

        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rdy0", {31'd0, req0_ready}, (win == 0) ? 32'd1 : 32'd0);
        check("idle_rdy1", {31'd0, req1_ready}, (win == 1) ? 32'd1 : 32'd0);
        step();

        @(negedge clk);
        check("calc_busy",  {31'd0, busy}, 32'd1);
        check("calc_rdys",  {30'd0, req1_ready, req0_ready}, 32'd0);
        check("calc_rvld",  {31'd0, rsp_valid}, 32'd0);
        check("calc_mul_a", {28'd0, mul_a}, ea);
        check("calc_mul_b", {28'd0, mul_b}, eb);
        step();

        repeat (stall) begin
            @(negedge clk);
            check("hold_rvld", {31'd0, rsp_valid}, 32'd1);
            check("hold_prod", {24'd0, rsp_product}, ea * eb);
            check("hold_id",   {31'd0, rsp_id}, win);
            check("hold_rdys", {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        check("resp_rvld", {31'd0, rsp_valid}, 32'd1);
        check("resp_prod", {24'd0, rsp_product}, ea * eb);
        check("resp_id",   {31'd0, rsp_id}, win);
        check("resp_rdys", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("resp_cnt",  {30'd0, op_count}, m_cnt);
        step();

        rsp_ready = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_ptr = 1 - win;
        check("done_rvld",  {31'd0, rsp_valid}, 32'd0);
        check("done_busy",  {31'd0, busy}, 32'd0);
        check("done_cnt",   {30'd0, op_count}, m_cnt);
        check("done_mul_a", {28'd0, mul_a}, ea);
        check("done_mul_b", {28'd0, mul_b}, eb);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Present requests for part of a cycle, then withdraw them before the
    // clock edge: grant must follow the reference, and nothing is accepted.
    task automatic flicker(input bit v0, input bit v1);
        int win;
        win = (v0 && v1) ? m_ptr : (v0 ? 0 : (v1 ? 1 : 2));
        req0_valid = v0; req0_a = N'($urandom_range(0, 15)); req0_b = N'($urandom_range(0, 15));
        req1_valid = v1; req1_a = N'($urandom_range(0, 15)); req1_b = N'($urandom_range(0, 15));
        @(negedge clk);
        check("flk_rdy0", {31'd0, req0_ready}, (win == 0) ? 32'd1 : 32'd0);
        check("flk_rdy1", {31'd0, req1_ready}, (win == 1) ? 32'd1 : 32'd0);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check("flk_busy", {31'd0, busy}, 32'd0);
        check("flk_rvld", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int r;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        #12;

        // Reset state
        check("rst_rvld",  {31'd0, rsp_valid}, 32'd0);
        check("rst_prod",  {24'd0, rsp_product}, 32'd0);
        check("rst_id",    {31'd0, rsp_id}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_cnt",   {30'd0, op_count}, 32'd0);
        check("rst_mul_a", {28'd0, mul_a}, 32'd0);
        check("rst_mul_b", {28'd0, mul_b}, 32'd0);
        check("rst_rdys",  {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Largest operands, single requester
        do_op(1, 15, 15, 0, 0, 0, 0);
        // Both valid: pointer alternates the winner 1,0,1,0 from here
        do_op(1, 3, 5, 1, 9, 7, 0);
        do_op(1, 3, 5, 1, 9, 7, 0);
        do_op(1, 3, 5, 1, 9, 7, 0);
        do_op(1, 3, 5, 1, 9, 7, 0);
        do_op(1, 3, 5, 1, 9, 7, 0);
        // Back-pressure with a zero product
        do_op(0, 0, 0, 1, 12, 0, 5);

        // Reset while in CALC discards the operation
        req0_valid = 1'b1; req0_a = 4'd10; req0_b = 4'd11;
        step();
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        m_cnt = 0; m_ptr = 0;
        check("mid_busy",  {31'd0, busy}, 32'd0);
        check("mid_rvld",  {31'd0, rsp_valid}, 32'd0);
        check("mid_cnt",   {30'd0, op_count}, 32'd0);
        check("mid_mul_a", {28'd0, mul_a}, 32'd0);
        req0_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_op(1, 10, 11, 0, 0, 0, 0);
        // Pointer was cleared by reset, then moved to 1 by the op above
        do_op(1, 2, 2, 1, 4, 4, 1);
        do_op(1, 2, 2, 1, 4, 4, 0);

        // Randomized traffic, including withdrawn requests
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                flicker(r[0], r[1]);
            if (r == 0) r = 3;
            do_op(r[0], $urandom_range(0, 15), $urandom_range(0, 15),
                  r[1], $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
